// File: rtl/wb_host_pkg.sv
// Shared definitions for the Wishbone host master: field widths, default
// parameter values and the FSM state encoding.
package wb_host_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
  localparam int CNT_W = 16;

  localparam int               TIMEOUT_CYCLES_DEFAULT = 255;
  localparam logic [DAT_W-1:0] ERR_DATA_DEFAULT       = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic master. Takes one request over a
// valid/ready port, runs one bus cycle with an ack timeout, and returns one
// response over a valid/ready port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a request; bus idle
// ST_BUS  | cyc/stb asserted, waiting for ack or timeout
// ST_RESP | response presented, held until the consumer takes it
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int               TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [DAT_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,

  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [ADR_W-1:0] req_adr_i,
  input  logic [DAT_W-1:0] req_dat_i,
  input  logic [SEL_W-1:0] req_sel_i,

  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DAT_W-1:0] rsp_dat_o,
  output logic             rsp_err_o,

  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  output logic [SEL_W-1:0] wbm_sel_o,
  input  logic             wbm_ack_i,
  input  logic [DAT_W-1:0] wbm_dat_i,

  output logic             busy_o
);

  // The wait counter would reach the limit on this edge once it has counted
  // TIMEOUT_CYCLES-1 cycles without ack, so cyc/stb stay high exactly
  // TIMEOUT_CYCLES cycles on an abort.
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_e             state_q,   state_d;
  logic               we_q,      we_d;
  logic [ADR_W-1:0]   adr_q,     adr_d;
  logic [DAT_W-1:0]   dat_q,     dat_d;
  logic [SEL_W-1:0]   sel_q,     sel_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  // Next-state and datapath capture; ack wins over a coincident timeout.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          adr_d   = req_adr_i;
          dat_d   = req_dat_i;
          sel_d   = req_sel_i;
          cnt_d   = '0;
          state_d = ST_BUS;
        end
      end

      ST_BUS: begin
        if (wbm_ack_i) begin
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
          rsp_err_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_RESP;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          rsp_dat_d = ERR_DATA;
          rsp_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RESP;
        end else begin
          cnt_d     = cnt_inc;
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured fields; reset drops cyc/stb at once and discards
  // any pending response.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

  // stb is the same decode as cyc: no pipelined or burst cycles.
  assign wbm_cyc_o   = (state_q == ST_BUS);
  assign wbm_stb_o   = (state_q == ST_BUS);
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master: directed scenarios plus randomized
// transactions against a behavioural response model.
module tb_wb_host_master;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [31:0] req_dat = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, wbm_we;
  logic [31:0] wbm_adr, wbm_dat_o;
  logic [3:0]  wbm_sel;
  logic        ack = 1'b0;
  logic [31:0] wbm_dat_i = '0;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  wb_host_master #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_adr_i   (req_adr),
    .req_dat_i   (req_dat),
    .req_sel_i   (req_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (wbm_we),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel),
    .wbm_ack_i   (ack),
    .wbm_dat_i   (wbm_dat_i),
    .busy_o      (busy)
  );

  // Drives one transaction starting at a negedge in IDLE and returns what
  // was observed; protocol/stability violations are tallied in viol.
  // The slave acks after ack_wait wait cycles; the consumer stalls
  // rsp_delay cycles; junk keeps a bogus request asserted while busy.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_wait, input logic [31:0] rdata,
                         input int rsp_delay, input bit junk,
                         output int cyc_len, output logic r_valid,
                         output logic [31:0] r_dat, output logic r_err, output int viol);
    int k;
    viol = 0;
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    @(negedge clk);
    if (junk) begin
      req_we = ~we; req_adr = ~adr; req_dat = ~dat; req_sel = ~sel;
    end else begin
      req_valid = 1'b0;
    end
    k = 0;
    while (cyc === 1'b1 && k < 200) begin
      k++;
      if (stb !== 1'b1 || wbm_we !== we || wbm_adr !== adr || wbm_dat_o !== dat ||
          wbm_sel !== sel || req_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0)
        viol++;
      ack = (k == ack_wait + 1);
      wbm_dat_i = ack ? rdata : $urandom;
      @(negedge clk);
    end
    cyc_len = k;
    r_valid = rsp_valid;
    r_dat   = rsp_dat;
    r_err   = rsp_err;
    if (stb !== 1'b0) viol++;
    for (int i = 0; i < rsp_delay; i++) begin
      ack = 1'b1;
      wbm_dat_i = $urandom;
      if (rsp_valid !== 1'b1 || rsp_dat !== r_dat || rsp_err !== r_err ||
          req_ready !== 1'b0 || busy !== 1'b1 || cyc !== 1'b0 || stb !== 1'b0)
        viol++;
      @(negedge clk);
    end
    if (rsp_valid !== 1'b1 || rsp_dat !== r_dat || rsp_err !== r_err || req_ready !== 1'b0)
      viol++;
    ack = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || cyc !== 1'b0)
      viol++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (cyc !== 1'b0 || stb !== 1'b0 || wbm_we !== 1'b0) begin
      bad++; $display("FAIL reset_ctl: cyc=%b stb=%b we=%b exp 0 0 0", cyc, stb, wbm_we); end
    total++; if (wbm_adr !== 32'h0 || wbm_dat_o !== 32'h0 || wbm_sel !== 4'h0) begin
      bad++; $display("FAIL reset_fields: adr=%h dat=%h sel=%h exp 0", wbm_adr, wbm_dat_o, wbm_sel); end
    total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== 32'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_rsp: valid=%b err=%b dat=%h busy=%b exp 0", rsp_valid, rsp_err, rsp_dat, busy); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: req_ready=%b exp 1", req_ready); end
  endtask

  task automatic test_write();
    int len, viol; logic v, e; logic [31:0] d;
    run_txn(1'b1, 32'h3000_0010, 32'hA5A5_0001, 4'hF, 3, 32'hDEAD_BEEF, 0, 1'b0, len, v, d, e, viol);
    total++; if (len !== 4) begin bad++; $display("FAIL write_cyc_len: got %0d exp 4", len); end
    total++; if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      bad++; $display("FAIL write_rsp: valid=%b dat=%h err=%b exp 1 0 0", v, d, e); end
    total++; if (viol !== 0) begin bad++; $display("FAIL write_protocol: violations=%0d exp 0", viol); end
  endtask

  task automatic test_read_min();
    int len, viol; logic v, e; logic [31:0] d;
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 32'h1234_5678, 0, 1'b0, len, v, d, e, viol);
    total++; if (len !== 1) begin bad++; $display("FAIL read_cyc_len: got %0d exp 1", len); end
    total++; if (v !== 1'b1 || d !== 32'h1234_5678 || e !== 1'b0) begin
      bad++; $display("FAIL read_rsp: valid=%b dat=%h err=%b exp 1 12345678 0", v, d, e); end
    total++; if (viol !== 0) begin bad++; $display("FAIL read_protocol: violations=%0d exp 0", viol); end
  endtask

  task automatic test_timeout();
    int len, viol; logic v, e; logic [31:0] d;
    run_txn(1'b0, 32'h3000_0100, 32'h0, 4'h3, 1000, 32'h5555_AAAA, 0, 1'b0, len, v, d, e, viol);
    total++; if (len !== TO) begin bad++; $display("FAIL timeout_cyc_len: got %0d exp %0d", len, TO); end
    total++; if (v !== 1'b1 || d !== 32'hFFFF_FFFF || e !== 1'b1) begin
      bad++; $display("FAIL timeout_rsp: valid=%b dat=%h err=%b exp 1 ffffffff 1", v, d, e); end
    total++; if (viol !== 0) begin bad++; $display("FAIL timeout_protocol: violations=%0d exp 0", viol); end
  endtask

  task automatic test_ack_on_timeout();
    int len, viol; logic v, e; logic [31:0] d;
    run_txn(1'b0, 32'h3000_0200, 32'h0, 4'hC, TO - 1, 32'hCAFE_0042, 0, 1'b0, len, v, d, e, viol);
    total++; if (len !== TO) begin bad++; $display("FAIL ack_to_cyc_len: got %0d exp %0d", len, TO); end
    total++; if (v !== 1'b1 || d !== 32'hCAFE_0042 || e !== 1'b0) begin
      bad++; $display("FAIL ack_to_rsp: valid=%b dat=%h err=%b exp 1 cafe0042 0", v, d, e); end
    total++; if (viol !== 0) begin bad++; $display("FAIL ack_to_protocol: violations=%0d exp 0", viol); end
  endtask

  task automatic test_backpressure();
    int len, viol; logic v, e; logic [31:0] d;
    run_txn(1'b0, 32'h3000_0300, 32'h0, 4'h1, 2, 32'h0BAD_F00D, 5, 1'b1, len, v, d, e, viol);
    total++; if (len !== 3 || v !== 1'b1 || d !== 32'h0BAD_F00D || e !== 1'b0) begin
      bad++; $display("FAIL bp_rsp: len=%0d valid=%b dat=%h err=%b exp 3 1 0badf00d 0", len, v, d, e); end
    total++; if (viol !== 0) begin bad++; $display("FAIL bp_protocol: violations=%0d exp 0", viol); end
    run_txn(1'b1, 32'h3000_0304, 32'h7777_8888, 4'h6, 0, 32'h1, 0, 1'b0, len, v, d, e, viol);
    total++; if (len !== 1 || d !== 32'h0 || e !== 1'b0 || viol !== 0) begin
      bad++; $display("FAIL bp_next: len=%0d dat=%h err=%b viol=%0d exp 1 0 0 0", len, d, e, viol); end
  endtask

  task automatic test_back_to_back();
    int len, viol, t0; logic v, e; logic [31:0] d;
    t0 = cycle;
    run_txn(1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, 32'h1111_2222, 0, 1'b0, len, v, d, e, viol);
    run_txn(1'b0, 32'h4000_0004, 32'h0, 4'hF, 0, 32'h3333_4444, 0, 1'b0, len, v, d, e, viol);
    total++; if (cycle - t0 !== 6) begin
      bad++; $display("FAIL b2b_cycles: got %0d exp 6", cycle - t0); end
    total++; if (d !== 32'h3333_4444 || viol !== 0) begin
      bad++; $display("FAIL b2b_rsp: dat=%h viol=%0d exp 33334444 0", d, viol); end
  endtask

  task automatic test_idle_ack();
    for (int i = 0; i < 4; i++) begin
      ack = 1'b1; wbm_dat_i = $urandom;
      @(negedge clk);
      total++; if (busy !== 1'b0 || cyc !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        bad++; $display("FAIL idle_ack: busy=%b cyc=%b rsp_valid=%b ready=%b exp 0 0 0 1",
                        busy, cyc, rsp_valid, req_ready); end
    end
    ack = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    int len, viol; logic v, e; logic [31:0] d;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h5000_0000; req_dat = 32'h9999_0000; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (cyc !== 1'b1) begin bad++; $display("FAIL rst_bus_pre: cyc=%b exp 1", cyc); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (cyc !== 1'b0 || stb !== 1'b0 || busy !== 1'b0 || wbm_adr !== 32'h0) begin
      bad++; $display("FAIL rst_bus_async: cyc=%b stb=%b busy=%b adr=%h exp 0 0 0 0", cyc, stb, busy, wbm_adr); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0 || cyc !== 1'b0) begin
        bad++; $display("FAIL rst_bus_after: rsp_valid=%b cyc=%b exp 0 0", rsp_valid, cyc); end
    end
    // reset while a response is pending
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h5000_0008;
    @(negedge clk);
    req_valid = 1'b0; ack = 1'b1; wbm_dat_i = 32'hABCD_0000;
    @(negedge clk);
    ack = 1'b0;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rst_resp_pre: rsp_valid=%b exp 1", rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || rsp_dat !== 32'h0) begin
      bad++; $display("FAIL rst_resp_async: rsp_valid=%b dat=%h exp 0 0", rsp_valid, rsp_dat); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 32'h5000_000C, 32'h0, 4'hF, 1, 32'h600D_600D, 0, 1'b0, len, v, d, e, viol);
    total++; if (len !== 2 || v !== 1'b1 || d !== 32'h600D_600D || e !== 1'b0 || viol !== 0) begin
      bad++; $display("FAIL rst_next_txn: len=%0d valid=%b dat=%h err=%b viol=%0d exp 2 1 600d600d 0 0",
                      len, v, d, e, viol); end
  endtask

  task automatic test_random();
    int len, viol, aw, exp_len; logic v, e, we, exp_err;
    logic [31:0] d, adr, dat, rdata, exp_dat; logic [3:0] sel;
    for (int n = 0; n < 30; n++) begin
      we = 1'(($urandom >> 3) & 1);
      adr = $urandom; dat = $urandom; rdata = $urandom; sel = 4'($urandom);
      aw = $urandom_range(0, 11);
      exp_err = (aw >= TO);
      exp_len = exp_err ? TO : aw + 1;
      exp_dat = exp_err ? ERR : (we ? 32'h0 : rdata);
      run_txn(we, adr, dat, sel, aw, rdata, $urandom_range(0, 3), 1'($urandom & 1),
              len, v, d, e, viol);
      total++; if (len !== exp_len || v !== 1'b1 || d !== exp_dat || e !== exp_err || viol !== 0) begin
        bad++; $display("FAIL rand_txn%0d: len=%0d valid=%b dat=%h err=%b viol=%0d exp %0d 1 %h %b 0",
                        n, len, v, d, e, viol, exp_len, exp_dat, exp_err); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_min();
    test_timeout();
    test_ack_on_timeout();
    test_backpressure();
    test_back_to_back();
    test_idle_ack();
    test_reset_mid_bus();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/wb_host_master.md
WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles cyc/stb held waiting for ack before abort; legal range 1..65535.
REQ-002 Parameter ERR_DATA, default 32'hFFFF_FFFF: rsp_dat_o value returned on timeout.
REQ-003 wb_clk_i  input  1  sole clock; all state changes on rising edge.
REQ-004 wb_rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid_i  input  1  request present.
REQ-006 req_ready_o  output  1  block can accept a request.
REQ-007 req_we_i  input  1  1 = write, 0 = read.
REQ-008 req_adr_i  input  32  byte address.
REQ-009 req_dat_i  input  32  write data.
REQ-010 req_sel_i  input  4  byte-lane select.
REQ-011 rsp_valid_o  output  1  response present.
REQ-012 rsp_ready_i  input  1  response consumer ready.
REQ-013 rsp_dat_o  output  32  read data; 0 for writes; ERR_DATA on timeout.
REQ-014 rsp_err_o  output  1  response is a timeout abort.
REQ-015 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic master controls.
REQ-016 wbm_adr_o  output  32; wbm_dat_o  output  32; wbm_sel_o  output  4  registered request fields.
REQ-017 wbm_ack_i  input  1; wbm_dat_i  input  32  slave acknowledge and read data.
REQ-018 busy_o  output  1  state is not IDLE.

Function
REQ-019 FSM states IDLE, BUS, RESP, all outputs registered or decoded from registered state only.
REQ-020 IDLE: req_ready_o=1; a request is accepted in the cycle req_valid_i && req_ready_o; fields captured; next state BUS.
REQ-021 Request accepted at edge N: wbm_cyc_o=wbm_stb_o=1 from cycle N+1, with adr/dat/sel/we stable for the whole BUS state.
REQ-022 BUS: wbm_ack_i sampled each edge; on ack, read data captured (writes capture 0), rsp_err=0, next state RESP; cyc/stb low the following cycle.
REQ-023 BUS: 16-bit wait counter cleared on entry, incremented per cycle without ack; on reaching TIMEOUT_CYCLES: cyc/stb dropped, rsp_dat=ERR_DATA, rsp_err=1, next state RESP.
REQ-024 Ack and timeout in the same cycle: ack wins, normal response, rsp_err=0.
REQ-025 RESP: rsp_valid_o=1, rsp_dat_o/rsp_err_o held stable until rsp_valid_o && rsp_ready_i; then IDLE.
REQ-026 Minimum round trip: request edge N, ack sampled at N+1, rsp_valid_o high at N+2, next request acceptable at N+3 at the earliest.
REQ-027 wbm_ack_i in IDLE or RESP ignored; no state or data change.
REQ-028 req_ready_o=0 in BUS and RESP; req_valid_i ignored there.
REQ-029 One outstanding transaction only; no pipelined or burst cycles; wbm_stb_o == wbm_cyc_o always.

Reset
REQ-030 wb_rst_ni low forces state IDLE immediately, independent of clock.
REQ-031 Reset values: wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o=wbm_dat_o=0, wbm_sel_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, busy_o=0, counter=0; req_ready_o=1 once reset deasserts.
REQ-032 Reset mid-BUS aborts the cycle with no response generated; a pending response in RESP is discarded.

Structure
REQ-033 Shared package wb_host_pkg holds the FSM state enum, the default TIMEOUT_CYCLES and ERR_DATA constants, and the request/response field widths.
REQ-034 Single flat module; no sub-module required.

Verification
REQ-035 Write: req adr=32'h3000_0010, dat=32'hA5A5_0001, sel=4'hF, we=1; slave acks after 3 wait cycles -> wbm_we_o=1, cyc high 4 cycles, rsp_valid_o with rsp_dat_o=0 and rsp_err_o=0.
REQ-036 Read: req adr=32'h3000_0004, we=0; slave acks at first sample with dat=32'h1234_5678 -> rsp_dat_o=32'h1234_5678 at N+2.
REQ-037 Timeout: TIMEOUT_CYCLES=8, slave never acks -> cyc/stb low after 8 BUS cycles, rsp_err_o=1, rsp_dat_o=32'hFFFF_FFFF.
REQ-038 Ack on the timeout cycle -> rsp_err_o=0, slave data returned.
REQ-039 Backpressure: rsp_ready_i held low 5 cycles -> rsp_valid_o and data held stable, req_ready_o=0 throughout, new request accepted only after the handshake.
REQ-040 Reset asserted during BUS -> cyc/stb low asynchronously, no rsp_valid_o after release, next request completes normally.
